// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two-requester command front end for a bank of JK cells.
// A command names a cell, a JK operation and a repeat count; the arbiter
// drives J/K for that cell over cnt cycles (0 = 16), then pulses done.
// Optional build macro JK_FIXED_PRIO_EN: on a tie req0 always wins instead
// of round-robin (last_grant is still tracked).

// One JK storage cell; updates only when enabled by the sequencer.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);
  // JK next-state on enable: 00 hold, 01 reset, 10 set, 11 toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= 1'b0;
    else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_bank_arbiter #(
  parameter int N_CELLS = 8,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [IDX_W-1:0]   req0_idx,
  input  logic [1:0]         req0_op,
  input  logic [3:0]         req0_cnt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [IDX_W-1:0]   req1_idx,
  input  logic [1:0]         req1_op,
  input  logic [3:0]         req1_cnt,
  output logic [N_CELLS-1:0] q,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  localparam logic [IDX_W:0] NC = (IDX_W+1)'(N_CELLS);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         op_q;
  logic [4:0]         rem_q;
  logic               gid_q;
  logic               last_grant_q;
  logic               bad_idx_q;
  logic               done_q;
  logic               done_id_q;
  logic               err_q;

  logic               acc;
  logic               acc_id;
  logic [IDX_W-1:0]   sel_idx;
  logic [1:0]         sel_op;
  logic [3:0]         sel_cnt;
  logic [N_CELLS-1:0] cell_en;

  // Grant: only in IDLE and never during reset; ties go to the requester
  // that did not win last (or always req0 with fixed priority).
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
`ifdef JK_FIXED_PRIO_EN
        req0_ready = 1'b1;
`else
        if (last_grant_q) req0_ready = 1'b1;
        else              req1_ready = 1'b1;
`endif
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign acc     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_id  = req1_valid && req1_ready;
  assign sel_idx = acc_id ? req1_idx : req0_idx;
  assign sel_op  = acc_id ? req1_op  : req0_op;
  assign sel_cnt = acc_id ? req1_cnt : req0_cnt;

  // Command sequencer: capture on accept, count down APPLY cycles, one-cycle DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      op_q         <= 2'b00;
      rem_q        <= 5'd0;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      bad_idx_q    <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (acc) begin
            idx_q        <= sel_idx;
            op_q         <= sel_op;
            rem_q        <= {sel_cnt == 4'd0, sel_cnt};
            gid_q        <= acc_id;
            last_grant_q <= acc_id;
            bad_idx_q    <= ({1'b0, sel_idx} >= NC);
            state_q      <= S_APPLY;
          end
        end
        S_APPLY: begin
          rem_q <= rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            done_id_q <= gid_q;
            err_q     <= bad_idx_q;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One cell per index; out-of-range indices match no cell.
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    assign cell_en[i] = (state_q == S_APPLY) && (idx_q == IDX_W'(i));
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en[i]),
      .j   (op_q[1]),
      .k   (op_q[0]),
      .q   (q[i])
    );
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Owns a bank of N_CELLS JK flip-flop cells and shares it between two command requesters.
- Each command names a cell, a JK operation and a repeat count. The block arbitrates, sequences the J/K drive for that cell over the required cycles, then reports completion.
- Sits between control logic and the JK storage, so no requester drives J/K directly.

Parameters:
- N_CELLS, 8, number of JK cells in the bank (2..16)
- IDX_W, 4, width of the cell index field; must satisfy 2**IDX_W >= N_CELLS

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this edge if valid
- req0_idx  in  IDX_W  target cell index
- req0_op  in  2  operation: 00 hold (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1)
- req0_cnt  in  4  repeat count; 0 means 16 cycles
- req1_valid, req1_ready, req1_idx, req1_op, req1_cnt  same as requester 0, for requester 1
- q  out  N_CELLS  current JK cell states
- busy  out  1  a command is in progress (APPLY or DONE)
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester whose command completed; valid while done=1
- err  out  1  with done: completed command had idx >= N_CELLS

Behaviour:
- Reset (async, immediate): q=0, state=IDLE, busy=0, done=0, done_id=0, err=0, last_grant=1, both ready=0 combinationally while rst=1.
- FSM states: IDLE, APPLY, DONE.
- IDLE, ready rules:
  - Only req0 valid: req0_ready=1.
  - Only req1 valid: req1_ready=1.
  - Both valid: ready goes to the requester != last_grant.
  - Ready is never 1 for both requesters; ready=0 in APPLY and DONE.
- Ready is combinational from valid/state/last_grant. The requester must hold idx/op/cnt stable while valid=1.
- Accept edge (valid&ready in IDLE):
  - Capture idx, op, rem=cnt (0 -> 16) and grant id.
  - last_grant <= grant id; go to APPLY.
- APPLY, each edge:
  - Cell idx gets the JK update: hold q; reset 0; set 1; toggle ~q.
  - Other cells keep their value.
  - rem decrements; at rem==1 go to DONE.
  - Total APPLY cycles = cnt, with 0 meaning 16.
  - idx >= N_CELLS: no cell changes, cycle count is unchanged, err latched.
- DONE: done=1 and done_id=grant id for exactly one cycle; err valid in the same cycle. Then go to IDLE.
- Latency: accept at edge t0, first q change at edge t1, last change at t_cnt, done high in cycle after t_cnt, next accept possible at edge t_cnt+2.
- busy=1 in APPLY and DONE.
- A requester holding valid after acceptance issues a new command and competes normally.
- Requests arriving while busy are stalled (ready=0), not dropped.
- Reset mid-command: command discarded, no done pulse, q cleared.

Optional Feature:
- Macro: JK_FIXED_PRIO_EN.
- Defined: when both requesters are valid, req0 always wins. last_grant is still tracked but ignored.
- Undefined: round-robin as described; req0 wins the first tie after reset.

Test Plan:
- Reset then req0 {idx=2, op=10, cnt=1} -> q=0x04 one edge after accept; done=1, done_id=0, err=0 next cycle; req0_ready=1 again the cycle after.
- From q=0x04, req1 {idx=2, op=11, cnt=3} -> q[2] goes 0,1,0 on three successive edges; done_id=1 after the third edge.
- Both valid every IDLE cycle (req0 {idx=0, op=10, cnt=1}, req1 {idx=1, op=10, cnt=1}) -> grants alternate 0,1,0,1. With JK_FIXED_PRIO_EN defined -> always 0.
- req0 {idx=9, op=10, cnt=2} with N_CELLS=8 -> q unchanged for 2 cycles; done=1 with err=1.
- req0 {idx=5, op=11, cnt=0} -> 16 toggles, q[5] returns to its start value; busy high for 17 cycles.
- req1 {idx=3, op=10, cnt=8}, assert rst at 4th APPLY cycle -> q=0 immediately, no done pulse, req1_ready=1 first IDLE cycle after rst falls.
